// File: rtl/char_buf_pkg.sv
// Shared constants and FSM state type for the character buffer controller.
package char_buf_pkg;

  localparam logic [7:0] CHAR_BS = 8'h08;
  localparam logic [7:0] CHAR_LF = 8'h0A;
  localparam logic [7:0] CHAR_CR = 8'h0D;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CLEAR  = 2'd1,
    ST_ROWCLR = 2'd2
  } state_e;

endpackage

// File: rtl/char_buf_mem.sv
// Simple dual-port cell storage: synchronous write, registered read.
// A same-cycle read of the cell being written returns the old contents.
module char_buf_mem #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 128,
  parameter int AW    = 7
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_array [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem_array[waddr] <= wdata;
    end
    rdata_q <= mem_array[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/char_buffer_ctrl.sv
// Text-screen character buffer: cursor tracking, control codes, clear sweep.
// Define CHAR_BUFFER_SCROLL_EN to scroll (base offset + row clear) instead of wrapping.
module char_buffer_ctrl
  import char_buf_pkg::*;
#(
  parameter int DATA_WIDTH = 9,
  parameter int ROWS       = 4,
  parameter int COLS       = 32,
  parameter int TAG_WIDTH  = 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic [TAG_WIDTH-1:0]    wr_tag,
  input  logic                    clr_req,
  output logic                    busy,
  input  logic [$clog2(ROWS)-1:0] rd_row,
  input  logic [$clog2(COLS)-1:0] rd_col,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic [TAG_WIDTH-1:0]    rd_tag,
  output logic [$clog2(ROWS)-1:0] cur_row,
  output logic [$clog2(COLS)-1:0] cur_col
);

  localparam int RW    = $clog2(ROWS);
  localparam int CW    = $clog2(COLS);
  localparam int DEPTH = ROWS * COLS;
  localparam int AW    = $clog2(DEPTH);
  localparam int MW    = DATA_WIDTH + TAG_WIDTH;

  localparam logic [RW-1:0] ROW_LAST  = RW'(ROWS - 1);
  localparam logic [CW-1:0] COL_LAST  = CW'(COLS - 1);
  localparam logic [AW-1:0] CELL_LAST = AW'(DEPTH - 1);

  state_e        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [RW-1:0] cur_row_q, cur_row_d;
  logic [CW-1:0] cur_col_q, cur_col_d;
  logic [RW-1:0] base_q, base_d;
  logic          rd_zero_q, rd_zero_d;
`ifdef CHAR_BUFFER_SCROLL_EN
  logic [RW-1:0] clr_row_q, clr_row_d;
`endif

  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [MW-1:0] mem_wdata;
  logic [AW-1:0] mem_raddr;
  logic [MW-1:0] mem_rdata;
  logic          wr_accept;
  logic          row_adv;
  logic          rd_oob;

  // Logical row is rotated by the base offset before flattening to an address.
  function automatic logic [AW-1:0] cell_addr(input logic [RW-1:0] lrow,
                                              input logic [CW-1:0] col,
                                              input logic [RW-1:0] base);
    logic [RW:0] sum;
    sum = {1'b0, lrow} + {1'b0, base};
    if (sum >= (RW+1)'(ROWS)) begin
      sum = sum - (RW+1)'(ROWS);
    end
    return AW'(sum[RW-1:0]) * AW'(COLS) + AW'(col);
  endfunction

  assign wr_ready  = (state_q == ST_IDLE) && !clr_req;
  assign busy      = (state_q != ST_IDLE);
  assign wr_accept = wr_valid && wr_ready;
  assign cur_row   = cur_row_q;
  assign cur_col   = cur_col_q;

  assign rd_oob    = (int'(rd_row) >= ROWS) || (int'(rd_col) >= COLS);
  assign mem_raddr = rd_oob ? '0 : cell_addr(rd_row, rd_col, base_q);
  assign rd_zero_d = rd_oob;
  assign rd_data   = rd_zero_q ? '0 : mem_rdata[MW-1:TAG_WIDTH];
  assign rd_tag    = rd_zero_q ? '0 : mem_rdata[TAG_WIDTH-1:0];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cur_row_d = cur_row_q;
    cur_col_d = cur_col_q;
    base_d    = base_q;
`ifdef CHAR_BUFFER_SCROLL_EN
    clr_row_d = clr_row_q;
`endif
    row_adv   = 1'b0;
    mem_we    = 1'b0;
    mem_waddr = '0;
    mem_wdata = '0;

    case (state_q)
      ST_CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = cnt_q;
        if (cnt_q == CELL_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`ifdef CHAR_BUFFER_SCROLL_EN
      ST_ROWCLR: begin
        mem_we    = 1'b1;
        mem_waddr = AW'(clr_row_q) * AW'(COLS) + AW'(cnt_q[CW-1:0]);
        if (cnt_q[CW-1:0] == COL_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`endif
      ST_IDLE: begin
        if (wr_accept) begin
          if (wr_data == DATA_WIDTH'(CHAR_CR)) begin
            cur_col_d = '0;
          end else if (wr_data == DATA_WIDTH'(CHAR_LF)) begin
            cur_col_d = '0;
            row_adv   = 1'b1;
          end else if (wr_data == DATA_WIDTH'(CHAR_BS)) begin
            if (cur_col_q != '0) begin
              cur_col_d = cur_col_q - 1'b1;
              mem_we    = 1'b1;
              mem_waddr = cell_addr(cur_row_q, cur_col_q - 1'b1, base_q);
            end
          end else begin
            mem_we    = 1'b1;
            mem_waddr = cell_addr(cur_row_q, cur_col_q, base_q);
            mem_wdata = {wr_data, wr_tag};
            if (cur_col_q == COL_LAST) begin
              cur_col_d = '0;
              row_adv   = 1'b1;
            end else begin
              cur_col_d = cur_col_q + 1'b1;
            end
          end
        end
      end
      default: ;
    endcase

    if (row_adv) begin
      if (cur_row_q != ROW_LAST) begin
        cur_row_d = cur_row_q + 1'b1;
      end else begin
`ifdef CHAR_BUFFER_SCROLL_EN
        // The new bottom physical row is the one that used to be the top.
        base_d    = (base_q == ROW_LAST) ? '0 : base_q + 1'b1;
        clr_row_d = base_q;
        state_d   = ST_ROWCLR;
        cnt_d     = '0;
`else
        cur_row_d = '0;
`endif
      end
    end

    if (clr_req && (state_q != ST_CLEAR)) begin
      state_d   = ST_CLEAR;
      cnt_d     = '0;
      cur_row_d = '0;
      cur_col_d = '0;
      base_d    = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_CLEAR;
      cnt_q     <= '0;
      cur_row_q <= '0;
      cur_col_q <= '0;
      base_q    <= '0;
      rd_zero_q <= 1'b1;
`ifdef CHAR_BUFFER_SCROLL_EN
      clr_row_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cur_row_q <= cur_row_d;
      cur_col_q <= cur_col_d;
      base_q    <= base_d;
      rd_zero_q <= rd_zero_d;
`ifdef CHAR_BUFFER_SCROLL_EN
      clr_row_q <= clr_row_d;
`endif
    end
  end

  char_buf_mem #(
    .WIDTH (MW),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (mem_waddr),
    .wdata (mem_wdata),
    .raddr (mem_raddr),
    .rdata (mem_rdata)
  );

endmodule

// File: tb/tb_char_buffer_ctrl.sv
// Bench for char_buffer_ctrl: logical-screen model checked every cycle plus
// directed transactions with literal expectations.
module tb_char_buffer_ctrl;

  localparam int ROWS = 4;
  localparam int COLS = 32;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       wr_valid = 1'b0;
  logic       wr_ready;
  logic [8:0] wr_data = '0;
  logic [0:0] wr_tag = '0;
  logic       clr_req = 1'b0;
  logic       busy;
  logic [1:0] rd_row = '0;
  logic [4:0] rd_col = '0;
  logic [8:0] rd_data;
  logic [0:0] rd_tag;
  logic [1:0] cur_row;
  logic [4:0] cur_col;

  int n_vec = 0;
  int n_err = 0;

  char_buffer_ctrl dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .wr_data  (wr_data),
    .wr_tag   (wr_tag),
    .clr_req  (clr_req),
    .busy     (busy),
    .rd_row   (rd_row),
    .rd_col   (rd_col),
    .rd_data  (rd_data),
    .rd_tag   (rd_tag),
    .cur_row  (cur_row),
    .cur_col  (cur_col)
  );

  always #5 clk = ~clk;

  // Model: logical screen contents (rows shift on scroll), cursor, busy length.
  logic [9:0] scr [ROWS][COLS];
  int         m_row, m_col;
  int         busy_cnt;
  bit         in_clear;
  bit         rd_chk;
  logic [8:0] exp_rd_data;
  logic [0:0] exp_rd_tag;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_zero();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        scr[r][c] = '0;
  endtask

  task automatic model_advance();
    if (m_row < ROWS - 1) begin
      m_row++;
    end else begin
`ifdef CHAR_BUFFER_SCROLL_EN
      for (int r = 0; r < ROWS - 1; r++)
        for (int c = 0; c < COLS; c++)
          scr[r][c] = scr[r+1][c];
      for (int c = 0; c < COLS; c++)
        scr[ROWS-1][c] = '0;
      busy_cnt = COLS;
      in_clear = 1'b0;
`else
      m_row = 0;
`endif
    end
  endtask

  task automatic model_reset();
    model_zero();
    m_row = 0;
    m_col = 0;
    busy_cnt = ROWS * COLS;
    in_clear = 1'b1;
    rd_chk = 1'b1;
    exp_rd_data = '0;
    exp_rd_tag = '0;
  endtask

  task automatic model_step();
    if (!reset_n) begin
      model_reset();
      return;
    end
    rd_chk = (busy_cnt == 0);
    {exp_rd_data, exp_rd_tag} = scr[rd_row][rd_col];
    if (clr_req && !in_clear) begin
      model_zero();
      m_row = 0;
      m_col = 0;
      busy_cnt = ROWS * COLS;
      in_clear = 1'b1;
    end else if (busy_cnt > 0) begin
      busy_cnt--;
      if (busy_cnt == 0) in_clear = 1'b0;
    end else if (wr_valid && !clr_req) begin
      if (wr_data == 9'h00D) begin
        m_col = 0;
      end else if (wr_data == 9'h00A) begin
        m_col = 0;
        model_advance();
      end else if (wr_data == 9'h008) begin
        if (m_col > 0) begin
          m_col--;
          scr[m_row][m_col] = '0;
        end
      end else begin
        scr[m_row][m_col] = {wr_data, wr_tag};
        if (m_col == COLS - 1) begin
          m_col = 0;
          model_advance();
        end else begin
          m_col++;
        end
      end
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      check("busy", 32'(busy), 32'(busy_cnt != 0));
      check("wr_ready", 32'(wr_ready), 32'((busy_cnt == 0) && !clr_req));
      check("cur_row", 32'(cur_row), 32'(m_row));
      check("cur_col", 32'(cur_col), 32'(m_col));
      if (rd_chk) begin
        check("rd_data", 32'(rd_data), 32'(exp_rd_data));
        check("rd_tag", 32'(rd_tag), 32'(exp_rd_tag));
      end
    end
  end

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic busy_span(input int pulse_at, output int n);
    n = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (!busy) break;
      n++;
      @(posedge clk);
      #1;
      clr_req = (n == pulse_at);
    end
    clr_req = 1'b0;
    sync();
  endtask

  task automatic put(input logic [8:0] d, input logic t);
    bit ok;
    ok = 1'b0;
    wr_valid = 1'b1;
    wr_data = d;
    wr_tag = t;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge clk);
      ok = wr_ready;
      sync();
    end
    wr_valid = 1'b0;
    if (!ok) check("put_accept", 32'(ok), 32'd1);
    $display("wr data=0x%03h tag=%0d -> cursor (%0d,%0d)", d, t, cur_row, cur_col);
  endtask

  task automatic do_read(input int r, input int c, output logic [8:0] d, output logic [0:0] t);
    rd_row = 2'(r);
    rd_col = 5'(c);
    sync();
    d = rd_data;
    t = rd_tag;
    $display("rd (%0d,%0d) -> data=0x%03h tag=%0d", r, c, d, t);
  endtask

  task automatic do_clear();
    int n;
    clr_req = 1'b1;
    sync();
    clr_req = 1'b0;
    busy_span(-1, n);
    check("clear_busy_len", 32'(n), 32'd128);
    $display("clear -> busy for %0d cycles", n);
  endtask

  initial begin
    int n;
    logic [8:0] d;
    logic [0:0] t;

    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", 32'(busy), 32'd1);
    check("reset_ready", 32'(wr_ready), 32'd0);
    reset_n = 1'b1;

    // Power-up sweep
    busy_span(-1, n);
    check("release_busy_len", 32'(n), 32'd128);
    check("ready_after_sweep", 32'(wr_ready), 32'd1);
    do_read(0, 5, d, t);
    check("rd_0_5", 32'(d), 32'h0);

    // Single character with tag
    put(9'h041, 1'b1);
    check("a_cur_row", 32'(cur_row), 32'd0);
    check("a_cur_col", 32'(cur_col), 32'd1);
    do_read(0, 0, d, t);
    check("a_data", 32'(d), 32'h041);
    check("a_tag", 32'(t), 32'd1);

    // Full-row line wrap
    do_clear();
    for (int i = 0; i < COLS; i++) put(9'h042, 1'b0);
    check("wrap_cur_row", 32'(cur_row), 32'd1);
    check("wrap_cur_col", 32'(cur_col), 32'd0);
    do_read(0, 31, d, t);
    check("wrap_rd_0_31", 32'(d), 32'h042);

    // Backspace
    do_clear();
    put(9'h043, 1'b0);
    put(9'h044, 1'b0);
    put(9'h008, 1'b0);
    check("bs_cur_row", 32'(cur_row), 32'd0);
    check("bs_cur_col", 32'(cur_col), 32'd1);
    do_read(0, 1, d, t);
    check("bs_rd_0_1", 32'(d), 32'h0);
    do_read(0, 0, d, t);
    check("bs_rd_0_0", 32'(d), 32'h043);
    put(9'h008, 1'b0);
    put(9'h008, 1'b0);
    check("bs_at_col0", 32'(cur_col), 32'd0);

    // CR then LF on the bottom row
    do_clear();
    put(9'h061, 1'b0);
    put(9'h00A, 1'b0);
    put(9'h062, 1'b1);
    put(9'h00A, 1'b0);
    put(9'h00A, 1'b0);
    put(9'h063, 1'b0);
    put(9'h00D, 1'b0);
    check("cr_cur_col", 32'(cur_col), 32'd0);
    check("cr_cur_row", 32'(cur_row), 32'd3);
    put(9'h00A, 1'b0);
`ifdef CHAR_BUFFER_SCROLL_EN
    check("lf_cur_row", 32'(cur_row), 32'd3);
    check("lf_cur_col", 32'(cur_col), 32'd0);
    busy_span(-1, n);
    check("rowclr_busy_len", 32'(n), 32'd32);
    do_read(3, 0, d, t);
    check("scroll_row3", 32'(d), 32'h0);
    do_read(0, 0, d, t);
    check("scroll_row0", 32'(d), 32'h062);
    check("scroll_row0_tag", 32'(t), 32'd1);
`else
    check("lf_cur_row", 32'(cur_row), 32'd0);
    check("lf_cur_col", 32'(cur_col), 32'd0);
    check("lf_busy", 32'(busy), 32'd0);
    do_read(0, 0, d, t);
    check("wrap_row0_kept", 32'(d), 32'h061);
    do_read(3, 0, d, t);
    check("wrap_row3_kept", 32'(d), 32'h063);
`endif

    // clr_req and wr_valid together; second clr_req mid-sweep is ignored
    put(9'h064, 1'b0);
    clr_req = 1'b1;
    wr_valid = 1'b1;
    wr_data = 9'h055;
    @(negedge clk);
    check("clr_wr_ready", 32'(wr_ready), 32'd0);
    sync();
    clr_req = 1'b0;
    wr_valid = 1'b0;
    busy_span(10, n);
    check("clr_busy_len", 32'(n), 32'd128);
    check("clr_cur_row", 32'(cur_row), 32'd0);
    check("clr_cur_col", 32'(cur_col), 32'd0);
    do_read(0, 0, d, t);
    check("clr_rd_0_0", 32'(d), 32'h0);
    $display("clr+wr -> busy for %0d cycles", n);

    repeat (2) sync();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
